uart_tx_engine: RTL and testbench

- Serial transmit engine of the APB UART.
- It is the reader side of the TX FIFO. It pops bytes through a valid/ready handshake and serialises each one onto tx_o as start, data, optional parity and stop bits.
- Draining the FIFO is what decrements the TX element count that the interrupt logic watches for "holding register empty".
- It sits between the TX FIFO output and the UART pad.

---
 rtl/uart_tx_engine.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// Serial transmit engine of the APB UART. This block reads bytes from the
// TX FIFO through a valid/ready pop and shifts each byte out on tx_o. The
// frame is a start bit, 5..8 data bits sent LSB first, an optional parity
// bit, and one or two stop bits. Popping the FIFO is what lowers the TX
// element count that the interrupt logic watches.
//
// Ports:
//   clk_i         clock
//   rstn_i        asynchronous active-low reset
//   cfg_en_i      transmitter enable; only gates acceptance of new bytes
//   div_i         baud divisor; one bit period is div_i+1 clocks
//   bits_i        data length: 00=5, 01=6, 10=7, 11=8 bits
//   parity_en_i   insert a parity bit
//   parity_even_i 1=even parity, 0=odd parity
//   stop2_i       0=one stop bit, 1=two stop bits
//   tx_data_i     byte at the TX FIFO head
//   tx_valid_i    TX FIFO not empty
//   tx_ready_o    pop strobe to the TX FIFO
//   tx_o          serial line, idle high, driven straight from a flop
//   busy_o        frame in progress
module uart_tx_engine #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [1:0]           bits_i,
  input  logic                 parity_en_i,
  input  logic                 parity_even_i,
  input  logic                 stop2_i,
  input  logic [7:0]           tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [DIV_WIDTH-1:0] BAUD_ONE = DIV_WIDTH'(1);

  state_t               state;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] div_lat;
  logic [2:0]           bit_cnt;
  logic [7:0]           data_lat;
  logic [1:0]           bits_lat;
  logic                 par_en_lat;
  logic                 par_even_lat;
  logic                 stop2_lat;
  logic                 tx_q;
  logic                 bit_done;
  logic                 last_data;
  logic                 accept;

  // Parity over only the bits actually sent; odd parity inverts the XOR so
  // the total number of ones on the line matches the selected sense.
  function automatic logic parity_bit(input logic [7:0] d,
                                      input logic [1:0] bl,
                                      input logic       even);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - bl);
    return (^(d & mask)) ^ ~even;
  endfunction

  // Ready is gated by reset as well, so the FIFO sees no pop strobe while
  // the engine is held in reset.
  assign tx_ready_o = (state == IDLE) & cfg_en_i & rstn_i;
  assign busy_o     = (state != IDLE);
  assign tx_o       = tx_q;
  assign accept     = tx_valid_i & tx_ready_o;
  assign bit_done   = (baud_cnt == div_lat);
  assign last_data  = (bit_cnt == (3'd4 + {1'b0, bits_lat}));

  // The next line level is loaded at each bit boundary, so tx_o changes
  // exactly when a new bit period starts and never glitches.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      div_lat      <= '0;
      data_lat     <= '0;
      bits_lat     <= '0;
      par_en_lat   <= 1'b0;
      par_even_lat <= 1'b0;
      stop2_lat    <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (accept) begin
            data_lat     <= tx_data_i;
            bits_lat     <= bits_i;
            par_en_lat   <= parity_en_i;
            par_even_lat <= parity_even_i;
            stop2_lat    <= stop2_i;
            div_lat      <= div_i;
            state        <= START;
            tx_q         <= 1'b0;
          end else begin
            tx_q <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx_q     <= data_lat[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (last_data) begin
              bit_cnt <= '0;
              if (par_en_lat) begin
                state <= PARITY;
                tx_q  <= parity_bit(data_lat, bits_lat, par_even_lat);
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= data_lat[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= STOP;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        STOP: begin
          // bit_cnt counts stop bits already finished.
          if (bit_done) begin
            baud_cnt <= '0;
            tx_q     <= 1'b1;
            if (stop2_lat && (bit_cnt == 3'd0)) begin
              bit_cnt <= 3'd1;
            end else begin
              bit_cnt <= '0;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine
// Self-checking bench for uart_tx_engine. A reference model turns each byte
// and its frame settings into the expected per-clock line level, which is
// compared with tx_o, busy_o and tx_ready_o on every falling edge.
module tb_uart_tx_engine;

  logic        clk;
  logic        rstn;
  logic        cfg_en;
  logic [15:0] div;
  logic [1:0]  bits;
  logic        par_en;
  logic        par_even;
  logic        stop2;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;
  bit exp_q[$];

  uart_tx_engine #(.DIV_WIDTH(16)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .cfg_en_i      (cfg_en),
    .div_i         (div),
    .bits_i        (bits),
    .parity_en_i   (par_en),
    .parity_even_i (par_even),
    .stop2_i       (stop2),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .tx_o          (tx),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count FIFO pops as the FIFO itself would see them.
  always @(posedge clk) if (tx_valid && tx_ready) pops <= pops + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: append the expected per-clock line levels of one frame.
  task automatic build_exp(input logic [7:0] d, input int n, input bit pe,
                           input bit pev, input bit s2, input int dv);
    bit b[$];
    int ones;
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      b.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) b.push_back(pev ? bit'(ones % 2) : bit'((ones + 1) % 2));
    b.push_back(1'b1);
    if (s2) b.push_back(1'b1);
    foreach (b[i]) repeat (dv + 1) exp_q.push_back(b[i]);
  endtask

  task automatic set_cfg(input logic [7:0] d, input logic [1:0] bl, input bit pe,
                         input bit pev, input bit s2, input int dv);
    cfg_en   = 1'b1;
    tx_data  = d;
    bits     = bl;
    par_en   = pe;
    par_even = pev;
    stop2    = s2;
    div      = 16'(dv);
  endtask

  // Entered at the first falling edge after the accept edge. idle_idx marks
  // a sample expected to be the inter-frame idle cycle; drop_idx is where
  // tx_valid is released.
  task automatic run_exp(input string tag, input bit scramble, input int pops0,
                         input int exp_pops, input int idle_idx, input int drop_idx);
    foreach (exp_q[i]) begin
      chk({tag, "_tx"}, 32'(tx), 32'(exp_q[i]));
      if (i == idle_idx) begin
        chk({tag, "_gap_busy"}, 32'(busy), 0);
        chk({tag, "_gap_rdy"}, 32'(tx_ready), 1);
      end else begin
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_rdy"}, 32'(tx_ready), 0);
      end
      if (i == drop_idx) begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end
      if (scramble) begin
        bits     = 2'($urandom_range(0, 3));
        div      = 16'($urandom_range(0, 5));
        par_en   = 1'($urandom);
        par_even = 1'($urandom);
        stop2    = 1'($urandom);
        cfg_en   = 1'($urandom);
      end
      @(negedge clk);
    end
    #1;
    chk({tag, "_end_tx"}, 32'(tx), 1);
    chk({tag, "_end_busy"}, 32'(busy), 0);
    chk({tag, "_end_rdy"}, 32'(tx_ready), 32'(cfg_en));
    chk({tag, "_pops"}, 32'(pops - pops0), 32'(exp_pops));
    cfg_en = 1'b1;
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input logic [1:0] bl,
                            input bit pe, input bit pev, input bit s2, input int dv,
                            input bit scramble);
    int p0;
    exp_q.delete();
    build_exp(d, 5 + int'(bl), pe, pev, s2, dv);
    @(negedge clk);
    p0 = pops;
    set_cfg(d, bl, pe, pev, s2, dv);
    tx_valid = 1'b1;
    #1;
    chk({tag, "_pre_rdy"}, 32'(tx_ready), 1);
    @(negedge clk);
    run_exp(tag, scramble, p0, 1, -1, 0);
  endtask

  initial begin
    int p0;
    rstn     = 1'b0;
    tx_valid = 1'b1;
    set_cfg(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(tx_ready), 0);
    chk("rst_pops", 32'(pops), 0);
    tx_valid = 1'b0;
    rstn     = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(tx_ready), 1);

    // Directed frames from the plan
    send_frame("8n1_55", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    send_frame("7e1_c1", 8'hC1, 2'b10, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    send_frame("5o2_03", 8'h03, 2'b00, 1'b1, 1'b0, 1'b1, 1, 1'b0);

    // Back-to-back with tx_valid held high
    exp_q.delete();
    build_exp(8'hA5, 8, 1'b0, 1'b0, 1'b0, 0);
    exp_q.push_back(1'b1);
    build_exp(8'h3C, 8, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    p0 = pops;
    set_cfg(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 0);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C;
    run_exp("b2b", 1'b0, p0, 2, 10, 11);

    // Config scrambled mid-frame, including cfg_en
    send_frame("scr_a", 8'h9E, 2'b11, 1'b1, 1'b0, 1'b1, 2, 1'b1);
    send_frame("scr_b", 8'h4B, 2'b01, 1'b0, 1'b1, 1'b0, 3, 1'b1);

    // cfg_en low holds off the pop even with data waiting
    @(negedge clk);
    p0 = pops;
    set_cfg(8'hD2, 2'b11, 1'b1, 1'b1, 1'b0, 1);
    cfg_en   = 1'b0;
    tx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_tx", 32'(tx), 1);
      chk("hold_busy", 32'(busy), 0);
      chk("hold_rdy", 32'(tx_ready), 0);
    end
    chk("hold_pops", 32'(pops - p0), 0);
    cfg_en = 1'b1;
    exp_q.delete();
    build_exp(8'hD2, 8, 1'b1, 1'b1, 1'b0, 1);
    @(negedge clk);
    run_exp("resume", 1'b0, p0, 1, -1, 0);

    // Reset in the middle of the data bits
    @(negedge clk);
    set_cfg(8'hF0, 2'b11, 1'b0, 1'b0, 1'b0, 1);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rstn = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdy", 32'(tx_ready), 0);
    @(negedge clk);
    rstn = 1'b1;
    send_frame("post_rst", 8'h6D, 2'b11, 1'b1, 1'b0, 1'b0, 2, 1'b0);

    // Randomized frames against the model
    for (int k = 0; k < 24; k++) begin
      send_frame("rand", 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 4), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
